// File: rtl/uart_cmd_deframer.sv
// UART command deframer: hunts SYNC, collects CMD/LEN/payload/CHK,
// holds checksum-valid frames until acked and strobes errors otherwise.
module uart_cmd_deframer #(
    parameter int          MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 4800
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic                         rx_frame_err,
    output logic                         frame_valid,
    output logic [7:0]                   frame_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
    output logic [7:0]                   rd_data,
    input  logic                         frame_ack,
    output logic                         err_valid,
    output logic [2:0]                   err_code,
    output logic [15:0]                  good_cnt
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]    MAX_B    = 8'(MAX_LEN);
    // Firing one count early puts the strobe exactly TIMEOUT_CLKS after the byte
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 2);

    localparam logic [2:0] E_FRAME = 3'd1;
    localparam logic [2:0] E_LEN   = 3'd2;
    localparam logic [2:0] E_CHK   = 3'd3;
    localparam logic [2:0] E_TMO   = 3'd4;
    localparam logic [2:0] E_OVR   = 3'd5;

    typedef enum logic [2:0] {
        S_SYNC,
        S_CMD,
        S_LEN,
        S_DATA,
        S_CHK,
        S_HOLD
    } state_t;

    state_t        state;
    logic [7:0]    buf_q [MAX_LEN];
    logic [LW-1:0] idx;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_nx;
    logic [7:0]    cmd_q;
    logic [7:0]    sum;
    logic [TW-1:0] tmo;

    assign idx_nx = idx + LW'(1);

    if (MAX_LEN < (2 ** AW)) begin : g_rd_chk
        assign rd_data = (rd_addr < AW'(MAX_LEN)) ? buf_q[rd_addr] : 8'h00;
    end else begin : g_rd_full
        assign rd_data = buf_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_SYNC;
            frame_valid <= 1'b0;
            frame_cmd   <= 8'h00;
            frame_len   <= '0;
            err_valid   <= 1'b0;
            err_code    <= 3'd0;
            good_cnt    <= 16'd0;
            idx         <= '0;
            len_q       <= '0;
            cmd_q       <= 8'h00;
            sum         <= 8'h00;
            tmo         <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            err_valid <= 1'b0;
            err_code  <= 3'd0;
            if (state == S_SYNC) begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state <= S_CMD;
                    tmo   <= '0;
                end
            end else if (state == S_HOLD) begin
                if (rx_valid) begin
                    err_valid <= 1'b1;
                    err_code  <= E_OVR;
                end
                if (frame_ack) begin
                    state       <= S_SYNC;
                    frame_valid <= 1'b0;
                end
            end else if (rx_frame_err) begin
                state     <= S_SYNC;
                err_valid <= 1'b1;
                err_code  <= E_FRAME;
            end else if (rx_valid) begin
                tmo <= '0;
                unique case (state)
                    S_CMD: begin
                        cmd_q <= rx_data;
                        sum   <= rx_data;
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        if (rx_data > MAX_B) begin
                            state     <= S_SYNC;
                            err_valid <= 1'b1;
                            err_code  <= E_LEN;
                        end else begin
                            len_q <= rx_data[LW-1:0];
                            sum   <= sum + rx_data;
                            idx   <= '0;
                            state <= (rx_data == 8'h00) ? S_CHK : S_DATA;
                        end
                    end
                    S_DATA: begin
                        buf_q[idx[AW-1:0]] <= rx_data;
                        sum <= sum + rx_data;
                        idx <= idx_nx;
                        if (idx_nx == len_q) begin
                            state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (rx_data == sum) begin
                            state       <= S_HOLD;
                            frame_valid <= 1'b1;
                            frame_cmd   <= cmd_q;
                            frame_len   <= len_q;
                            if (good_cnt != 16'hFFFF) begin
                                good_cnt <= good_cnt + 16'd1;
                            end
                        end else begin
                            state     <= S_SYNC;
                            err_valid <= 1'b1;
                            err_code  <= E_CHK;
                        end
                    end
                    default: begin
                        state <= S_SYNC;
                    end
                endcase
            end else if (tmo == TMO_LAST) begin
                state     <= S_SYNC;
                err_valid <= 1'b1;
                err_code  <= E_TMO;
            end else begin
                tmo <= tmo + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Directed bench for uart_cmd_deframer: per-cycle vector table plus
// hand-written timeout and reset sequences.
module tb_uart_cmd_deframer;

    localparam int TMO = 4800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_frame_err = 1'b0;
    logic        frame_valid;
    logic [7:0]  frame_cmd;
    logic [4:0]  frame_len;
    logic [3:0]  rd_addr = 4'd0;
    logic [7:0]  rd_data;
    logic        frame_ack = 1'b0;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [15:0] good_cnt;

    int n_vec = 0;
    int n_bad = 0;

    uart_cmd_deframer #(
        .MAX_LEN(16),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err),
        .frame_valid(frame_valid),
        .frame_cmd(frame_cmd),
        .frame_len(frame_len),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .frame_ack(frame_ack),
        .err_valid(err_valid),
        .err_code(err_code),
        .good_cnt(good_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        fe;
        logic        ack;
        logic [3:0]  ra;
        logic        fv;
        logic        ev;
        logic [2:0]  ec;
        logic [7:0]  cmd;
        logic [4:0]  len;
        logic [15:0] gc;
        logic [7:0]  rd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        logic v, logic [7:0] d, logic fe, logic ack, logic [3:0] ra,
        logic fv, logic ev, logic [2:0] ec, logic [7:0] cmd,
        logic [4:0] len, logic [15:0] gc, logic [7:0] rd);
        vec_t r;
        r.v = v; r.d = d; r.fe = fe; r.ack = ack; r.ra = ra;
        r.fv = fv; r.ev = ev; r.ec = ec; r.cmd = cmd;
        r.len = len; r.gc = gc; r.rd = rd;
        tbl.push_back(r);
    endfunction

    function automatic logic [41:0] obs();
        return {frame_valid, err_valid, err_code, frame_cmd,
                frame_len, good_cnt, rd_data};
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(logic v, logic [7:0] d, logic fe, logic ack);
        @(negedge clk);
        rx_valid     = v;
        rx_data      = d;
        rx_frame_err = fe;
        frame_ack    = ack;
        @(posedge clk);
        #1;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        frame_ack    = 1'b0;
    endtask

    initial begin
        int k;
        bit found;
        logic [41:0] exp;

        // good frame, overrun in hold, ack
        add(1,8'hA5,0,0,0, 0,0,0,8'h00,0,0,8'h00);
        add(1,8'h10,0,0,0, 0,0,0,8'h00,0,0,8'h00);
        add(1,8'h02,0,0,0, 0,0,0,8'h00,0,0,8'h00);
        add(1,8'h11,0,0,0, 0,0,0,8'h00,0,0,8'h11);
        add(1,8'h22,0,0,1, 0,0,0,8'h00,0,0,8'h22);
        add(1,8'h45,0,0,0, 1,0,0,8'h10,2,1,8'h11);
        add(0,8'h00,0,0,1, 1,0,0,8'h10,2,1,8'h22);
        add(1,8'h33,0,0,0, 1,1,5,8'h10,2,1,8'h11);
        add(0,8'h00,0,1,1, 0,0,0,8'h10,2,1,8'h22);
        // zero-length frame; ack with byte -> err 5, byte not parsed
        add(1,8'hA5,0,0,0, 0,0,0,8'h10,2,1,8'h11);
        add(1,8'h7F,0,0,0, 0,0,0,8'h10,2,1,8'h11);
        add(1,8'h00,0,0,0, 0,0,0,8'h10,2,1,8'h11);
        add(1,8'h7F,0,0,0, 1,0,0,8'h7F,0,2,8'h11);
        add(1,8'hA5,0,1,0, 0,1,5,8'h7F,0,2,8'h11);
        add(1,8'h10,0,0,0, 0,0,0,8'h7F,0,2,8'h11);
        // checksum error
        add(1,8'hA5,0,0,0, 0,0,0,8'h7F,0,2,8'h11);
        add(1,8'h10,0,0,0, 0,0,0,8'h7F,0,2,8'h11);
        add(1,8'h02,0,0,0, 0,0,0,8'h7F,0,2,8'h11);
        add(1,8'h11,0,0,0, 0,0,0,8'h7F,0,2,8'h11);
        add(1,8'h22,0,0,0, 0,0,0,8'h7F,0,2,8'h11);
        add(1,8'h46,0,0,0, 0,1,3,8'h7F,0,2,8'h11);
        // correct frame after checksum error; frame_err ignored in hold
        add(1,8'hA5,0,0,0, 0,0,0,8'h7F,0,2,8'h11);
        add(1,8'h20,0,0,0, 0,0,0,8'h7F,0,2,8'h11);
        add(1,8'h01,0,0,0, 0,0,0,8'h7F,0,2,8'h11);
        add(1,8'h05,0,0,0, 0,0,0,8'h7F,0,2,8'h05);
        add(1,8'h26,0,0,0, 1,0,0,8'h20,1,3,8'h05);
        add(0,8'h00,1,0,0, 1,0,0,8'h20,1,3,8'h05);
        add(0,8'h00,0,1,0, 0,0,0,8'h20,1,3,8'h05);
        // length error, then payload ignored, frame_err ignored in sync
        add(1,8'hA5,0,0,0, 0,0,0,8'h20,1,3,8'h05);
        add(1,8'h01,0,0,0, 0,0,0,8'h20,1,3,8'h05);
        add(1,8'h11,0,0,0, 0,1,2,8'h20,1,3,8'h05);
        add(1,8'h05,0,0,0, 0,0,0,8'h20,1,3,8'h05);
        add(0,8'h00,1,0,0, 0,0,0,8'h20,1,3,8'h05);
        // framing error mid-frame; frame_err beats rx_valid
        add(1,8'hA5,0,0,0, 0,0,0,8'h20,1,3,8'h05);
        add(0,8'h00,1,0,0, 0,1,1,8'h20,1,3,8'h05);
        add(1,8'hA5,0,0,0, 0,0,0,8'h20,1,3,8'h05);
        add(1,8'h10,1,0,0, 0,1,1,8'h20,1,3,8'h05);
        add(1,8'h10,0,0,0, 0,0,0,8'h20,1,3,8'h05);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'(obs()), 64'(42'd0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            rd_addr = tbl[i].ra;
            send(tbl[i].v, tbl[i].d, tbl[i].fe, tbl[i].ack);
            exp = {tbl[i].fv, tbl[i].ev, tbl[i].ec, tbl[i].cmd,
                   tbl[i].len, tbl[i].gc, tbl[i].rd};
            chk($sformatf("row%0d", i), 64'(obs()), 64'(exp));
        end
        rd_addr = 4'd0;

        // timeout: err 4 exactly TMO cycles after the CMD strobe
        send(1, 8'hA5, 0, 0);
        send(1, 8'h10, 0, 0);
        k = 1;
        found = 1'b0;
        while (k <= TMO + 8 && !found) begin
            if (err_valid) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        chk("tmo_cycles", 64'(k), 64'(TMO));
        chk("tmo_code", 64'(err_code), 64'(3'd4));
        @(posedge clk);
        #1;
        chk("tmo_one_shot", 64'(err_valid), 64'(1'b0));

        send(1, 8'hA5, 0, 0);
        send(1, 8'h30, 0, 0);
        send(1, 8'h00, 0, 0);
        send(1, 8'h30, 0, 0);
        chk("after_tmo_frame", 64'(obs()),
            64'({1'b1, 1'b0, 3'd0, 8'h30, 5'd0, 16'd4, 8'h05}));
        send(1, 8'h77, 0, 0);
        chk("hold_overrun", 64'(obs()),
            64'({1'b1, 1'b1, 3'd5, 8'h30, 5'd0, 16'd4, 8'h05}));

        // async reset mid-frame clears everything at once
        send(0, 8'h00, 0, 1);
        send(1, 8'hA5, 0, 0);
        send(1, 8'h10, 0, 0);
        send(1, 8'h02, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'(obs()), 64'(42'd0));
        @(negedge clk);
        rst_n = 1'b1;

        send(1, 8'hA5, 0, 0);
        send(1, 8'h10, 0, 0);
        send(1, 8'h02, 0, 0);
        send(1, 8'h11, 0, 0);
        send(1, 8'h22, 0, 0);
        send(1, 8'h45, 0, 0);
        chk("post_reset_frame", 64'(obs()),
            64'({1'b1, 1'b0, 3'd0, 8'h10, 5'd2, 16'd1, 8'h11}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
